// File: rtl/counter_non_recycling.sv
// Saturating up-counter for the microwave timer input path: counts 0..MAX_COUNT,
// holds at the terminal value, and only the synchronous reset returns it to 0.
module counter_non_recycling #(
    parameter int WIDTH      = 4,
    parameter int MAX_COUNT  = 9,
    parameter int INIT_VALUE = 0
) (
    input  logic             clk,
    input  logic             rst,
    output logic [WIDTH-1:0] q,
    output logic             tc
);

    localparam logic [WIDTH-1:0] MAX_Q  = WIDTH'(MAX_COUNT);
    localparam logic [WIDTH-1:0] INIT_Q = WIDTH'(INIT_VALUE);
    localparam logic [WIDTH-1:0] ONE_Q  = WIDTH'(1);

    // Power-up value is for simulation only; hardware relies on rst.
    logic [WIDTH-1:0] q_reg = INIT_Q;
    logic [WIDTH-1:0] q_next;

    // Above-terminal values can only come from an uninitialised register, so
    // they recover to 0 rather than being allowed to count further.
    always_comb begin
        q_next = q_reg;
        if (q_reg < MAX_Q) begin
            q_next = q_reg + ONE_Q;
        end else if (q_reg > MAX_Q) begin
            q_next = '0;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            q_reg <= '0;
        end else begin
            q_reg <= q_next;
        end
    end

    assign q  = q_reg;
    assign tc = (q_reg == MAX_Q);

endmodule

// File: tb/tb_counter_non_recycling.sv
// Bench for counter_non_recycling: directed checks from the test plan plus a
// randomized-reset phase compared every cycle against an edge-count model.
module tb_counter_non_recycling;

    logic       clk = 1'b0;
    logic       rst = 1'b0;
    logic       rst2 = 1'b0;
    logic [3:0] q;
    logic       tc;
    logic [3:0] q2;
    logic       tc2;

    int tests = 0;
    int fails = 0;

    counter_non_recycling #(.WIDTH(4), .MAX_COUNT(9)) u_dut (
        .clk (clk),
        .rst (rst),
        .q   (q),
        .tc  (tc)
    );

    counter_non_recycling #(.WIDTH(4), .MAX_COUNT(5), .INIT_VALUE(12)) u_dut2 (
        .clk (clk),
        .rst (rst2),
        .q   (q2),
        .tc  (tc2)
    );

    always #5 clk = ~clk;

    // Model: expected count is the number of non-reset edges since the last
    // reset, clipped at the terminal value. The second instance starts out of
    // range, so its first free edge only recovers to 0.
    int  cnt1 = 0;
    int  cnt2 = 0;
    bit  oor2 = 1'b1;

    always @(posedge clk) begin
        if (rst) cnt1 = 0; else cnt1 = cnt1 + 1;
        if (rst2) begin
            cnt2 = 0;
            oor2 = 1'b0;
        end else begin
            cnt2 = cnt2 + 1;
        end
    end

    function automatic int clip(input int n, input int m);
        return (n < m) ? n : m;
    endfunction

    function automatic int exp_q1();
        return clip(cnt1, 9);
    endfunction

    function automatic int exp_q2();
        if (oor2) return (cnt2 == 0) ? 12 : clip(cnt2 - 1, 5);
        return clip(cnt2, 5);
    endfunction

    task automatic check(input string name, input int got, input int exp);
        tests++;
        if (got !== exp) begin
            fails++;
            $display("FAIL %s: got %0d, expected %0d at %0t", name, got, exp, $time);
        end
    endtask

    bit cmp_en = 1'b0;

    always @(negedge clk) begin
        if (cmp_en) begin
            check("model_q",   int'(q),   exp_q1());
            check("model_tc",  int'(tc),  int'(exp_q1() == 9));
            check("model_q2",  int'(q2),  exp_q2());
            check("model_tc2", int'(tc2), int'(exp_q2() == 5));
        end
    end

    task automatic step(input logic r);
        rst = r;
        @(negedge clk);
    endtask

    initial begin
        #1;
        check("powerup_q",   int'(q),   0);
        check("powerup_tc",  int'(tc),  0);
        check("powerup_q2",  int'(q2),  12);
        check("powerup_tc2", int'(tc2), 0);
        cmp_en = 1'b1;

        for (int i = 0; i < 3; i++) begin
            step(1'b1);
            check("rst_hold_q", int'(q), 0);
            check("rst_hold_tc", int'(tc), 0);
            if (i == 0) check("oor_recover_q2", int'(q2), 0);
        end

        step(1'b1);
        step(1'b1);
        for (int i = 1; i <= 5; i++) begin
            step(1'b0);
            check("release_q", int'(q), i);
            check("release_tc", int'(tc), 0);
        end

        step(1'b1);
        for (int i = 1; i <= 18; i++) begin
            step(1'b0);
            check("sat_q", int'(q), (i < 9) ? i : 9);
            check("sat_tc", int'(tc), (i >= 9) ? 1 : 0);
        end

        step(1'b1);
        for (int i = 0; i < 6; i++) step(1'b0);
        check("mid_q6", int'(q), 6);
        step(1'b1);
        check("mid_rst_q", int'(q), 0);
        for (int i = 1; i <= 3; i++) begin
            step(1'b0);
            check("mid_resume_q", int'(q), i);
        end

        for (int i = 0; i < 6; i++) step(1'b0);
        check("term_q", int'(q), 9);
        check("term_tc", int'(tc), 1);
        step(1'b1);
        check("term_rst_q", int'(q), 0);
        check("term_rst_tc", int'(tc), 0);
        for (int i = 0; i < 9; i++) step(1'b0);
        check("term_again_q", int'(q), 9);
        check("term_again_tc", int'(tc), 1);

        check("var_sat_q2", int'(q2), 5);
        check("var_sat_tc2", int'(tc2), 1);

        for (int i = 0; i < 600; i++) begin
            rst  = ($urandom_range(0, 11) == 0);
            rst2 = ($urandom_range(0, 7) == 0);
            @(negedge clk);
        end

        cmp_en = 1'b0;
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
